lsu_data_mem: RTL

- Parametrised load/store memory unit for the RISC-V core's MEM stage. Successor to the combinational size-masking memory wrapper.
- Adds:
  - RV32I-correct byte/half/word loads with sign and zero extension.
  - Byte-lane stores.
  - Misalignment and out-of-bounds detection.
  - A configurable-latency valid/ready handshake that the pipeline uses as a stall source.
- Owns a DEPTH x 32-bit word-addressed data array.

---
 rtl/lsu_data_mem.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_data_mem.sv
// Load/store data memory for the MEM stage: RV32I sized loads and stores,
// alignment and range checking, and a fixed-latency request/response handshake
// whose busy flag stalls the pipeline while a request is in flight.
module lsu_data_mem #(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [3:0]    count;
  logic [AW+1:0] addr_q;
  logic [2:0]    funct3_q;
  logic          write_q;
  logic          misaligned_q;
  logic          fault_q;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word;

  logic          accept;
  logic          req_legal;
  logic          req_misaligned;
  logic          req_fault;
  logic [3:0]    req_be;
  logic [31:0]   req_lane_data;
  logic          store_en;
  logic          enter_resp;
  logic [AW-1:0] read_index;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  assign accept     = (state == IDLE) && req_valid;
  assign store_en   = accept && req_write && !req_fault && !req_misaligned;
  assign enter_resp = (next_state == RESP) && (state != RESP);
  // With single-cycle latency the read happens on the acceptance edge, before
  // the request has been latched, so the live address is used in that case.
  assign read_index = (state == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

  // Decode the incoming request: legality, natural alignment, byte lanes and
  // the store data replicated into every lane it might land in.
  always_comb begin
    req_legal      = 1'b0;
    req_be         = 4'b0000;
    req_lane_data  = req_wdata;
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3)
      3'b000: begin
        req_legal     = 1'b1;
        req_be        = 4'b0001 << req_addr[1:0];
        req_lane_data = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        req_legal     = 1'b1;
        req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lane_data = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        req_legal = 1'b1;
        req_be    = 4'b1111;
      end
      3'b100, 3'b101: begin
        req_legal = !req_write;
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
    req_fault = !req_legal || (req_addr >= MEM_BYTES);
  end

  // Data array: byte-lane stores commit on the acceptance edge, loads capture
  // the addressed word on the edge that enters the response state.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem[req_addr[AW+1:2]][8*b +: 8] <= req_lane_data[8*b +: 8];
        end
      end
    end
    if (enter_resp) begin
      rd_word <= mem[read_index];
    end
  end

  // Handshake state, latency counter and the latched request attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 4'd0;
      addr_q       <= '0;
      funct3_q     <= 3'd0;
      write_q      <= 1'b0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        count        <= CNT_LOAD;
        addr_q       <= req_addr[AW+1:0];
        funct3_q     <= req_funct3;
        write_q      <= req_write;
        misaligned_q <= req_misaligned;
        fault_q      <= req_fault;
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
    end
  end

  // Next-state logic: IDLE accepts, WAIT burns the remaining latency, RESP
  // presents the result for a single cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (count == 4'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Move the selected lane(s) to the LSBs and apply sign or zero extension.
  always_comb begin
    load_data = 32'd0;
    shifted   = rd_word >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  assign req_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign rsp_valid      = (state == RESP);
  assign rsp_misaligned = rsp_valid && misaligned_q;
  assign rsp_fault      = rsp_valid && fault_q;
  assign rsp_rdata      = (rsp_valid && !write_q && !misaligned_q && !fault_q)
                          ? load_data : 32'd0;

endmodule
